// File: rtl/spi_px_host_pkg.sv
// Shared types and default parameters for the host-side pixel SPI initiator.
package spi_host_pkg;

    localparam int MAX_PIXEL_BITS = 24;
    localparam int PX_BITS_DEF    = MAX_PIXEL_BITS;
    localparam int CLK_DIV_DEF    = 4;
    localparam int CS_GAP_DEF     = 2;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LEAD  = 3'd1,
        HIGH  = 3'd2,
        LOW   = 3'd3,
        TRAIL = 3'd4,
        GAP   = 3'd5
    } spi_state_e;

endpackage

// File: rtl/spi_px_host_if.sv
// Pixel valid/ready handshake bundle between the SPI host and its producer/consumer.
interface spi_px_host_if #(parameter int PX_BITS = spi_host_pkg::PX_BITS_DEF);

    logic [PX_BITS-1:0] px_i;
    logic               px_valid_i;
    logic               px_ready_o;
    logic [PX_BITS-1:0] px_o;
    logic               px_valid_o;
    logic               px_ready_i;

    modport slave (
        input  px_i, px_valid_i, px_ready_i,
        output px_ready_o, px_o, px_valid_o
    );

    modport master (
        output px_i, px_valid_i, px_ready_i,
        input  px_ready_o, px_o, px_valid_o
    );

endinterface

// File: rtl/spi_px_host_sync.sv
// Multi-flop synchronizer for an asynchronous single-bit input.
module spi_dep_signal_synchronizer #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic nreset_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;

    // shift chain next value
    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    // synchronizer flops
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            sync_q <= {STAGES{1'b0}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_px_host.sv
// SPI mode-0 initiator: sends one pixel word per CS frame MSB-first and returns
// the word captured from the device during the same frame.
module spi_px_host
    import spi_host_pkg::*;
#(
    parameter int PX_BITS = PX_BITS_DEF,
    parameter int CLK_DIV = CLK_DIV_DEF,
    parameter int CS_GAP  = CS_GAP_DEF
) (
    input  logic          clk_i,
    input  logic          nreset_i,
    spi_px_host_if.slave  px_if,
    output logic          spi_sck_o,
    output logic          spi_cs_o,
    output logic          spi_sdi_o,
    input  logic          spi_sdo_i
);

    localparam int PH_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
    localparam int PH_W   = $clog2(PH_MAX);
    localparam int BC_W   = $clog2(PX_BITS + 1);
    localparam logic [PH_W-1:0] DIV_LAST = PH_W'(CLK_DIV - 1);
    localparam logic [PH_W-1:0] GAP_LAST = PH_W'(CS_GAP - 1);

    spi_state_e         state_q, state_d;
    logic [PH_W-1:0]    ph_q, ph_d;
    logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [PX_BITS-1:0] tx_q, tx_d;
    logic [PX_BITS-1:0] rx_q, rx_d;
    logic [PX_BITS-1:0] px_q, px_d;
    logic               valid_q, valid_d;
    logic               ready_q, ready_d;
    logic               cs_q, cs_d;
    logic               sck_q, sck_d;
    logic               sdi_q, sdi_d;
    logic               sdo_sync_s;
    logic               div_last_s;

    spi_dep_signal_synchronizer #(.STAGES(2)) u_sdo_sync (
        .clk_i    (clk_i),
        .nreset_i (nreset_i),
        .d_i      (spi_sdo_i),
        .q_o      (sdo_sync_s)
    );

    assign div_last_s = (ph_q == DIV_LAST);

    // FSM state register
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (px_if.px_valid_i && ready_q) state_d = LEAD; else state_d = IDLE;
            LEAD:    if (div_last_s) state_d = HIGH; else state_d = LEAD;
            HIGH: begin
                if (div_last_s) begin
                    if (bit_cnt_q == BC_W'(1)) state_d = TRAIL;
                    else                       state_d = LOW;
                end else begin
                    state_d = HIGH;
                end
            end
            LOW:     if (div_last_s) state_d = HIGH; else state_d = LOW;
            TRAIL:   if (div_last_s) state_d = GAP; else state_d = TRAIL;
            GAP:     if (ph_q == GAP_LAST) state_d = IDLE; else state_d = GAP;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs and datapath next values; pins are derived from state_d so they register cleanly
    always_comb begin
        tx_d      = tx_q;
        rx_d      = rx_q;
        bit_cnt_d = bit_cnt_q;
        px_d      = px_q;
        valid_d   = valid_q;
        if (state_d != state_q) ph_d = {PH_W{1'b0}};
        else                    ph_d = ph_q + PH_W'(1);

        case (state_q)
            IDLE: begin
                if (state_d == LEAD) begin
                    tx_d      = px_if.px_i;
                    bit_cnt_d = BC_W'(PX_BITS);
                end else begin
                    tx_d      = tx_q;
                end
            end
            HIGH: begin
                if (div_last_s) begin
                    rx_d      = {rx_q[PX_BITS-2:0], sdo_sync_s};
                    bit_cnt_d = bit_cnt_q - BC_W'(1);
                end else begin
                    rx_d      = rx_q;
                end
            end
            LOW: begin
                if (ph_q == {PH_W{1'b0}}) tx_d = {tx_q[PX_BITS-2:0], 1'b0};
                else                      tx_d = tx_q;
            end
            TRAIL: begin
                if (div_last_s) begin
                    px_d    = rx_q;
                    valid_d = 1'b1;
                end else begin
                    px_d    = px_q;
                end
            end
            default: begin
                tx_d = tx_q;
            end
        endcase

        // consumption can only happen outside a frame, so it never collides with the TRAIL load
        if (valid_q && px_if.px_ready_i) valid_d = 1'b0;
        else                             valid_d = valid_d;

        cs_d    = !((state_d == LEAD) || (state_d == HIGH) || (state_d == LOW) || (state_d == TRAIL));
        sck_d   = (state_d == HIGH);
        sdi_d   = cs_d ? 1'b0 : tx_d[PX_BITS-1];
        ready_d = (state_d == IDLE) && !valid_d;
    end

    // datapath and registered output flops
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            ph_q      <= {PH_W{1'b0}};
            bit_cnt_q <= {BC_W{1'b0}};
            tx_q      <= {PX_BITS{1'b0}};
            rx_q      <= {PX_BITS{1'b0}};
            px_q      <= {PX_BITS{1'b0}};
            valid_q   <= 1'b0;
            ready_q   <= 1'b0;
            cs_q      <= 1'b1;
            sck_q     <= 1'b0;
            sdi_q     <= 1'b0;
        end else begin
            ph_q      <= ph_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            px_q      <= px_d;
            valid_q   <= valid_d;
            ready_q   <= ready_d;
            cs_q      <= cs_d;
            sck_q     <= sck_d;
            sdi_q     <= sdi_d;
        end
    end

    assign px_if.px_o       = px_q;
    assign px_if.px_valid_o = valid_q;
    assign px_if.px_ready_o = ready_q;
    assign spi_cs_o         = cs_q;
    assign spi_sck_o        = sck_q;
    assign spi_sdi_o        = sdi_q;

endmodule

// File: tb/tb_spi_px_host.sv
// Scoreboard bench for spi_px_host: loopback, tied-high SDO, back-to-back,
// backpressure, mid-frame reset and a behavioural slave model.
module tb_spi_px_host;

    logic clk = 1'b0;
    logic nreset = 1'b0;
    logic spi_sck, spi_cs, spi_sdi, spi_sdo;
    int   mode = 0;           // 0 loopback, 1 SDO tied high, 2 slave model

    int n_cmp = 0;
    int n_bad = 0;

    logic [23:0] exp_q[$];

    int chk_zero = 0;
    int last_gap = 0;

    logic        m_cs_p = 1'b1;
    logic        m_sck_p = 1'b0;
    logic [23:0] m_out = 24'h0;
    logic [23:0] m_in  = 24'h0;
    logic [23:0] m_resp = 24'h0;

    spi_px_host_if #(.PX_BITS(24)) px_if ();

    spi_px_host #(.PX_BITS(24), .CLK_DIV(4), .CS_GAP(2)) dut (
        .clk_i     (clk),
        .nreset_i  (nreset),
        .px_if     (px_if),
        .spi_sck_o (spi_sck),
        .spi_cs_o  (spi_cs),
        .spi_sdi_o (spi_sdi),
        .spi_sdo_i (spi_sdo)
    );

    always #5 clk = ~clk;

    assign spi_sdo = (mode == 0) ? spi_sdi : (mode == 1) ? 1'b1 : m_out[23];

    // behavioural device: returns the half-swapped previous word, first response zero
    always @(posedge clk) begin
        if (mode != 2) begin
            m_resp <= 24'h0;
            m_out  <= 24'h0;
            m_in   <= 24'h0;
        end else if (m_cs_p && !spi_cs) begin
            m_out <= m_resp;
            m_in  <= 24'h0;
        end else if (!spi_cs && spi_sck && !m_sck_p) begin
            m_in <= {m_in[22:0], spi_sdi};
        end else if (!spi_cs && !spi_sck && m_sck_p) begin
            m_out <= {m_out[22:0], 1'b0};
        end else if (!m_cs_p && spi_cs) begin
            m_resp <= {m_in[11:0], m_in[23:12]};
        end
        m_cs_p  <= spi_cs;
        m_sck_p <= spi_sck;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: timeout, got no event expected one", name);
    endtask

    // output scoreboard
    initial forever begin
        @(negedge clk);
        if (nreset && px_if.px_valid_o && px_if.px_ready_i) begin
            if (exp_q.size() == 0) begin
                fail("sb_unexpected_output");
            end else begin
                check("px_o", 32'(px_if.px_o), 32'(exp_q.pop_front()));
            end
        end
    end

    // frame shape monitor
    initial begin
        int lowc = 0, rises = 0, viol = 0, ones = 0, highc = 0, skip = 1;
        logic cs_p = 1'b1, sck_p = 1'b0, sdi_p = 1'b0;
        forever begin
            @(negedge clk);
            if (!nreset) begin
                skip = 1; lowc = 0; rises = 0; viol = 0; ones = 0; highc = 0;
            end else begin
                if (cs_p && !spi_cs) begin
                    last_gap = highc;
                    highc = 0; lowc = 0; rises = 0; viol = 0; ones = 0; skip = 0;
                end
                if (!spi_cs) begin
                    lowc++;
                    if (spi_sck && !sck_p) rises++;
                    if (spi_sck && (spi_sdi != sdi_p)) viol++;
                    if (spi_sdi) ones++;
                end else begin
                    highc++;
                end
                if (!cs_p && spi_cs && !skip) begin
                    check("cs_low_cycles", 32'(lowc), 32'd196);
                    check("sck_rises", 32'(rises), 32'd24);
                    check("sdi_change_sck_high", 32'(viol), 32'd0);
                    check("valid_with_cs_rise", 32'(px_if.px_valid_o), 32'd1);
                    if (chk_zero != 0) check("sdi_ones_in_frame", 32'(ones), 32'd0);
                end
            end
            cs_p = spi_cs; sck_p = spi_sck; sdi_p = spi_sdi;
        end
    end

    task automatic send(input logic [23:0] w, input bit push, input logic [23:0] e);
        int n = 0;
        px_if.px_i = w;
        px_if.px_valid_i = 1'b1;
        if (push) exp_q.push_back(e);
        forever begin
            @(negedge clk);
            if (px_if.px_ready_o) break;
            n++;
            if (n > 2000) begin fail("send_ready"); break; end
        end
        @(posedge clk); #1;
        px_if.px_valid_i = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(exp_q.size() == 0 && px_if.px_ready_o)) begin
            @(posedge clk); #1;
            n++;
            if (n > 1500) begin fail("wait_idle"); break; end
        end
    endtask

    initial begin
        int n;
        logic sck_prev;
        px_if.px_i = 24'h0;
        px_if.px_valid_i = 1'b0;
        px_if.px_ready_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cs", 32'(spi_cs), 32'd1);
        check("rst_sck", 32'(spi_sck), 32'd0);
        check("rst_sdi", 32'(spi_sdi), 32'd0);
        check("rst_ready", 32'(px_if.px_ready_o), 32'd0);
        check("rst_valid", 32'(px_if.px_valid_o), 32'd0);
        check("rst_px_o", 32'(px_if.px_o), 32'd0);
        nreset = 1'b1;
        check("ready_first_cycle", 32'(px_if.px_ready_o), 32'd0);
        @(posedge clk); #1;
        check("ready_after_first", 32'(px_if.px_ready_o), 32'd1);

        // loopback
        send(24'hA5C3F0, 1'b1, 24'hA5C3F0);
        wait_idle();

        // SDO tied high, zero word must keep SDI low
        mode = 1; chk_zero = 1;
        send(24'h000000, 1'b1, 24'hFFFFFF);
        wait_idle();
        chk_zero = 0; mode = 0;

        // back-to-back with valid held high
        send(24'h000001, 1'b1, 24'h000001);
        send(24'h800000, 1'b1, 24'h800000);
        wait_idle();
        check("b2b_cs_high_gap", 32'(last_gap), 32'd3);

        // backpressure
        send(24'h3C3C3C, 1'b1, 24'h3C3C3C);
        px_if.px_ready_i = 1'b0;
        px_if.px_i = 24'h0FF00F;
        px_if.px_valid_i = 1'b1;
        exp_q.push_back(24'h0FF00F);
        n = 0;
        while (!px_if.px_valid_o) begin
            @(posedge clk); #1;
            n++;
            if (n > 500) begin fail("bp_valid"); break; end
        end
        n = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (!spi_cs || px_if.px_ready_o || !px_if.px_valid_o) n++;
        end
        check("bp_held_cycles_bad", 32'(n), 32'd0);
        check("bp_px_o", 32'(px_if.px_o), 32'h3C3C3C);
        check("bp_ready", 32'(px_if.px_ready_o), 32'd0);
        px_if.px_ready_i = 1'b1;
        n = 0;
        while (spi_cs) begin
            @(posedge clk); #1;
            n++;
            if (n > 10) begin fail("bp_restart"); break; end
        end
        check("bp_restart_delay", 32'(n), 32'd2);
        px_if.px_valid_i = 1'b0;
        px_if.px_i = 24'hDEAD00;
        wait_idle();

        // reset at the 10th SCK rise
        send(24'h5A5A5A, 1'b0, 24'h0);
        n = 0;
        sck_prev = spi_sck;
        for (int c = 0; c < 600 && n < 10; c++) begin
            @(posedge clk); #1;
            if (spi_sck && !sck_prev) n++;
            sck_prev = spi_sck;
        end
        check("rst_mid_rises_seen", 32'(n), 32'd10);
        nreset = 1'b0;
        #1;
        check("mid_rst_cs", 32'(spi_cs), 32'd1);
        check("mid_rst_sck", 32'(spi_sck), 32'd0);
        check("mid_rst_valid", 32'(px_if.px_valid_o), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        nreset = 1'b1;
        check("mid_rst_ready0", 32'(px_if.px_ready_o), 32'd0);
        @(posedge clk); #1;
        check("mid_rst_ready1", 32'(px_if.px_ready_o), 32'd1);
        send(24'h123456, 1'b1, 24'h123456);
        wait_idle();

        // slave model returns response to the previous pixel
        mode = 2;
        @(posedge clk); #1;
        send(24'h111222, 1'b1, 24'h000000);
        send(24'hABCDEF, 1'b1, 24'h222111);
        send(24'h0F0F0F, 1'b1, 24'hDEFABC);
        wait_idle();

        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
